// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
// Accepts target Q bits over a valid/ready handshake and queues them in a
// small FIFO. Each clock it emits one registered J/K pair that makes a
// downstream JK element take the requested value on its next edge.
// When the FIFO is empty, an incoming bit bypasses storage, so a bit offered
// in cycle N appears on j/k in cycle N+1.
// Optional feature: define JK_DRIVER_CHECK_EN to compare q_fb against the
// expected Q two cycles after each driven pair. Each mismatch increments a
// saturating error counter. Without the macro, q_fb is ignored and err_cnt
// is held at 0.
module jk_excitation_driver #(
  parameter int DEPTH      = 4,
  parameter bit USE_TOGGLE = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_bit,
  output logic                     in_ready,
  input  logic                     drive_en,
  output logic                     j,
  output logic                     k,
  input  logic                     q_fb,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  typedef enum logic {ST_UNSYNC = 1'b0, ST_SYNC = 1'b1} state_t;

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  state_t           r_state;
  logic             r_q_exp;
  logic             r_j;
  logic             r_k;
  logic             r_vld_p1;

  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;
  logic   w_store;
  logic   w_take;
  logic   w_tgt;
  logic   w_j_nxt;
  logic   w_k_nxt;
  logic   w_qexp_nxt;
  state_t w_state_nxt;

  assign w_full   = (r_count == FULL_LVL);
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  // An empty FIFO forwards the incoming bit directly, giving one-cycle latency.
  assign w_pop    = drive_en && (!w_empty || w_push);
  assign w_store  = w_push && !(w_empty && w_pop);
  assign w_take   = w_pop && !w_empty;
  assign w_tgt    = w_empty ? in_bit : r_mem[r_rd_ptr];

  assign level = r_count;
  assign j     = r_j;
  assign k     = r_k;

  // FIFO storage array (data only, not reset)
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= in_bit;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_take)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_store, w_take})
        2'b10:   r_count <= r_count + ONE_LVL;
        2'b01:   r_count <= r_count - ONE_LVL;
        default: r_count <= r_count;
      endcase
    end
  end

  // Excitation decode for the popped target bit
  always_comb begin
    w_j_nxt     = 1'b0;
    w_k_nxt     = 1'b0;
    w_qexp_nxt  = r_q_exp;
    w_state_nxt = r_state;
    if (w_pop) begin
      if (r_state == ST_UNSYNC) begin
        w_j_nxt     = w_tgt;
        w_k_nxt     = !w_tgt;
        w_qexp_nxt  = w_tgt;
        w_state_nxt = ST_SYNC;
      end else if (w_tgt != r_q_exp) begin
        w_j_nxt    = USE_TOGGLE ? 1'b1 : w_tgt;
        w_k_nxt    = USE_TOGGLE ? 1'b1 : !w_tgt;
        w_qexp_nxt = w_tgt;
      end
    end
  end

  // Stage p1: registered J/K pair, sync state and pair-valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_j      <= 1'b0;
      r_k      <= 1'b0;
      r_state  <= ST_UNSYNC;
      r_vld_p1 <= 1'b0;
    end else begin
      r_j      <= w_j_nxt;
      r_k      <= w_k_nxt;
      r_state  <= w_state_nxt;
      r_vld_p1 <= w_pop;
    end
  end

  // Expected Q tracker; its validity is carried by r_state
  always_ff @(posedge clk) begin
    r_q_exp <= w_qexp_nxt;
  end

`ifdef JK_DRIVER_CHECK_EN
  logic             r_exp_p2;
  logic             r_vld_p2;
  logic [CNT_W-1:0] r_err_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p2: expected Q aligned with the element's returned Q
  always_ff @(posedge clk) begin
    r_exp_p2 <= r_q_exp;
  end

  // Stage p2 check valid and saturating mismatch counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p2 && (q_fb != r_exp_p2)) r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign busy    = !w_empty || r_vld_p1 || r_vld_p2;
  assign err_cnt = r_err_cnt;
`else
  logic w_unused_q_fb;
  assign w_unused_q_fb = q_fb;
  assign busy          = !w_empty || r_vld_p1;
  assign err_cnt       = '0;
`endif

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver: three instances share one stimulus
// stream (toggle mode, explicit set/reset mode, 2-bit error counter), each
// closing the loop through a behavioural JK element model.
module tb_jk_excitation_driver;

`ifdef JK_DRIVER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_bit, drive_en;
  logic f_en, f_val;

  logic       rdy_t, j_t, k_t, busy_t, qfb_t;
  logic [2:0] lvl_t;
  logic [7:0] err_t;
  logic       q_t = 1'b0;

  logic       rdy_x, j_x, k_x, busy_x, qfb_x;
  logic [2:0] lvl_x;
  logic [7:0] err_x;
  logic       q_x = 1'b0;

  logic       rdy_s, j_s, k_s, busy_s, qfb_s;
  logic [2:0] lvl_s;
  logic [1:0] err_s;
  logic       q_s = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jk_excitation_driver #(.DEPTH(4), .USE_TOGGLE(1'b1), .CNT_W(8)) u_tog (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(rdy_t),
    .drive_en(drive_en), .j(j_t), .k(k_t), .q_fb(qfb_t), .level(lvl_t),
    .busy(busy_t), .err_cnt(err_t));

  jk_excitation_driver #(.DEPTH(4), .USE_TOGGLE(1'b0), .CNT_W(8)) u_exp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(rdy_x),
    .drive_en(drive_en), .j(j_x), .k(k_x), .q_fb(qfb_x), .level(lvl_x),
    .busy(busy_x), .err_cnt(err_x));

  jk_excitation_driver #(.DEPTH(4), .USE_TOGGLE(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(rdy_s),
    .drive_en(drive_en), .j(j_s), .k(k_s), .q_fb(qfb_s), .level(lvl_s),
    .busy(busy_s), .err_cnt(err_s));

  // JK element models
  always @(posedge clk) begin
    case ({j_t, k_t})
      2'b01: q_t <= 1'b0;
      2'b10: q_t <= 1'b1;
      2'b11: q_t <= ~q_t;
      default: q_t <= q_t;
    endcase
    case ({j_x, k_x})
      2'b01: q_x <= 1'b0;
      2'b10: q_x <= 1'b1;
      2'b11: q_x <= ~q_x;
      default: q_x <= q_x;
    endcase
    case ({j_s, k_s})
      2'b01: q_s <= 1'b0;
      2'b10: q_s <= 1'b1;
      2'b11: q_s <= ~q_s;
      default: q_s <= q_s;
    endcase
  end

  assign qfb_t = f_en ? f_val : q_t;
  assign qfb_s = f_en ? f_val : q_s;
  assign qfb_x = q_x;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] t2_jt [4] = '{2'b10, 2'b11, 2'b00, 2'b11};
  logic [1:0] t2_jx [4] = '{2'b10, 2'b01, 2'b00, 2'b10};
  logic       t2_b  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       t4_b  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0] t4_jt [4] = '{2'b11, 2'b11, 2'b00, 2'b11};
  logic [1:0] t4_jx [4] = '{2'b01, 2'b10, 2'b00, 2'b01};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; drive_en = 1'b0;
    f_en = 1'b0; f_val = 1'b0;
    cyc(); cyc();
    check("rst_level", lvl_t, 0);
    check("rst_ready", rdy_t, 1);
    check("rst_jk", {j_t, k_t}, 0);
    check("rst_busy", busy_t, 0);
    check("rst_err", err_t, 0);

    // Test 1: single push with immediate drive
    rst = 1'b0; in_valid = 1'b1; in_bit = 1'b1; drive_en = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("t1_jk_tog", {j_t, k_t}, 2'b10);
    check("t1_jk_exp", {j_x, k_x}, 2'b10);
    check("t1_level", lvl_t, 0);
    check("t1_busy", busy_t, 1);
    cyc();
    check("t1_qfb", q_t, 1);
    check("t1_jk_idle", {j_t, k_t}, 2'b00);
    cyc(); cyc();
    check("t1_err", err_t, 0);

    // Tests 2/3: back-to-back stream 1,0,0,1 after reset
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_bit = t2_b[i];
      cyc();
      check($sformatf("t2_jk_tog%0d", i), {j_t, k_t}, t2_jt[i]);
      check($sformatf("t3_jk_exp%0d", i), {j_x, k_x}, t2_jx[i]);
      if (i > 0) check($sformatf("t2_qfb%0d", i - 1), q_t, t2_b[i-1]);
    end
    in_valid = 1'b0;
    cyc();
    check("t2_qfb3", q_t, 1);
    check("t2_jk_idle", {j_t, k_t}, 2'b00);
    cyc(); cyc();
    check("t2_err_tog", err_t, 0);
    check("t3_err_exp", err_x, 0);

    // Test 4: stalled fill, overflow refusal, then drain
    drive_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_bit = t4_b[i];
      check($sformatf("t4_ready%0d", i), rdy_t, (i < 4) ? 1 : 0);
      cyc();
    end
    check("t4_level_full", lvl_t, 4);
    check("t4_ready_full", rdy_t, 0);
    check("t4_jk_stall", {j_t, k_t}, 2'b00);
    in_bit = 1'b1; drive_en = 1'b1;
    check("t4_ready_pop", rdy_t, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      in_valid = 1'b0;
      check($sformatf("t4_level%0d", i), lvl_t, 3 - i);
      check($sformatf("t4_jk_tog%0d", i), {j_t, k_t}, t4_jt[i]);
      check($sformatf("t4_jk_exp%0d", i), {j_x, k_x}, t4_jx[i]);
      check($sformatf("t4_busy%0d", i), busy_t, 1);
    end
    cyc();
    check("t4_jk_after", {j_t, k_t}, 2'b00);
    cyc(); cyc();
    check("t4_busy_done", busy_t, 0);
    check("t4_err", err_t, 0);

    // Test 5: forced wrong feedback while expected Q is 1
    f_en = 1'b1; f_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();
    check("t5_err3_tog", err_t, CHK ? 3 : 0);
    check("t5_err3_sat", err_s, CHK ? 3 : 0);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();
    check("t5_err5_tog", err_t, CHK ? 5 : 0);
    check("t5_err_saturated", err_s, CHK ? 3 : 0);
    check("t5_err_exp_clean", err_x, 0);
    cyc(); cyc();
    check("t5_err_idle", err_t, CHK ? 5 : 0);
    f_en = 1'b0;

    // Test 6: reset mid-stream with queued bits
    drive_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = 1'b0;
      cyc();
    end
    in_valid = 1'b0;
    check("t6_level_pre", lvl_t, 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_level_rst", lvl_t, 0);
    check("t6_jk_rst", {j_t, k_t}, 2'b00);
    check("t6_err_rst", err_t, 0);
    check("t6_busy_rst", busy_t, 0);
    check("t6_ready_rst", rdy_t, 1);
    in_valid = 1'b1; in_bit = 1'b0; drive_en = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("t6_jk_unsync_tog", {j_t, k_t}, 2'b01);
    check("t6_jk_unsync_exp", {j_x, k_x}, 2'b01);
    cyc(); cyc(); cyc();
    check("t6_qfb", q_t, 0);
    check("t6_err_after", err_t, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
